note_sequencer: RTL and testbench
=================================

# note_sequencer

Plays an 8-step melody by driving one of the eight buzzer outputs (G6, F6, D6, B7, C6, A7, E6, C7) at a time. It replaces the free-running JK ripple counter and 3-to-8 decoder in the notes circuit with a programmable, clocked scheduler. Per-step note, duration and rest flags come from a small writable step table. Beat timing comes from an internal prescaler, and the block supports start, stop and loop control.

## Interface
- `TICK_DIV`, default 1000: clock cycles per beat, minimum 1.
- `GAP_CYCLES`, default 2: silent cycles inserted after every step, minimum 0.
- `STEPS`, default 8: number of table entries, fixed power of two, at most 8.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  start request, level-sampled.
- `stop`  in  1  abort request, level-sampled.
- `loop`  in  1  restart from step 0 after the last step, sampled at the end of the last gap.
- `wr_en`  in  1  step table write strobe.
- `wr_addr`  in  3  step table index.
- `wr_data`  in  6  step entry, packed as {rest, dur[1:0], note[2:0]}.
- `buzzer_en`  out  8  one-hot buzzer enable; bit i drives buzzer decoder output i.
- `step_idx`  out  3  index of the current step.
- `busy`  out  1  high while playing.
- `done`  out  1  one-cycle pulse on normal (non-stop) completion.

## Operation
- FSM states: IDLE, PLAY, GAP.
- **Reset** (`rst_n`=0 at an edge):
  - state goes to IDLE.
  - Step table is cleared to all zeros.
  - Prescaler and counters are zeroed.
  - `buzzer_en`=0, `step_idx`=0, `busy`=0, `done`=0.
- **IDLE to PLAY:** when `start`=1 and `stop`=0. The step pointer is set to 0 and entry 0 is latched.
- **Entry latch:** on entering PLAY, the step entry is copied into a working register. Table writes therefore never disturb a step that is already playing.
- **PLAY:**
  - `buzzer_en` = 1<<note, or 0 if rest=1.
  - Lasts exactly (dur+1)*`TICK_DIV` cycles. The prescaler restarts at step entry.
  - Then moves to GAP. If `GAP_CYCLES`=0, it moves directly to the next step.
- **GAP:** `buzzer_en`=0 for `GAP_CYCLES` cycles. After that:
  - If not the last step: pointer+1, go to PLAY.
  - If last step (`STEPS`-1) and `loop`=1: pointer wraps to 0, go to PLAY.
  - If last step and `loop`=0: go to IDLE with `done`=1 for that first IDLE cycle.
- **`stop`=1** in any state: the next cycle is IDLE, with `buzzer_en`=0, `busy`=0, `step_idx`=0 and no `done` pulse.
  - `stop` beats `start` in the same cycle.
  - `stop` beats loop wrap.
- **`start` while busy:** ignored; there is no restart.
- **`start` held high across completion:** `start` is seen again in the `done` cycle. The next melody begins the cycle after `done`.
- **Writes:**
  - Accepted in every state, including the same cycle as `start`.
  - A write to entry 0 in the `start` cycle is not seen by that first step; the old value is latched.
  - A write to the current step takes effect on its next play.
- **Reserved bits:** none; all 3-bit note codes are valid.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start latency: `start` sampled in cycle c gives `busy`=1, `step_idx`=0 and `buzzer_en` valid in cycle c+1.
- Step period = (dur+1)*`TICK_DIV` + `GAP_CYCLES` cycles.
- `step_idx` updates in the same cycle `buzzer_en` changes to the new note.
- `done` is asserted in the cycle after the last gap cycle, together with `busy`=0.
- Reset mid-play takes effect at the next edge. The table is also cleared.
- Duration counter width: 2 bits of beats plus a ceil(log2(`TICK_DIV`))-bit prescaler, with no overflow at `TICK_DIV` maximum.

## Structure
- Package `note_seq_pkg` holds:
  - `step_t` packed struct {rest, dur, note}.
  - `state_t` enum {IDLE, PLAY, GAP}.
  - Note constants: NOTE_G6=0, NOTE_F6=1, NOTE_D6=2, NOTE_B7=3, NOTE_C6=4, NOTE_A7=5, NOTE_E6=6, NOTE_C7=7.
- Sub-module `beat_timer`:
  - Prescaler plus beat counter.
  - Inputs: `clear`, `beats`. Output: one-cycle `expire`.
  - Reused for gap counting, with beats=0 and a divider override.
- Top level holds the FSM, the step table (8x6 flops) and the output registers.

## Test plan
All scenarios use `TICK_DIV`=4 and `GAP_CYCLES`=2.
- **Reset values:** assert `rst_n`=0 for 2 cycles, then release.
  - Required: all outputs 0.
  - Required: reading back all entries via playback gives note 0, 1 beat each.
- **Scale, no loop:** table = notes 0..7, dur 0, `loop`=0; `start` pulsed at cycle 0.
  - Step k occupies cycles 1+6k to 4+6k: `buzzer_en`=0x01<<k, `step_idx`=k.
  - Gap at cycles 5+6k and 6+6k: `buzzer_en`=0.
  - `done`=1 only at cycle 49.
- **Duration and rest:** entry 0 = {0,3,NOTE_A7}, entry 1 = {1,1,x}.
  - `buzzer_en`=0x20 for 16 cycles, then 0 for 2 + 8 + 2 cycles.
- **Loop:** `loop`=1.
  - After step 7's gap, `step_idx`=0 with no `done` pulse.
  - Drop `loop`: the next pass ends with `done`.
- **Stop:** `stop`=1 mid-PLAY of step 3.
  - Next cycle: `buzzer_en`=0, `busy`=0, `step_idx`=0, `done` never pulses.
  - `start`+`stop` together in IDLE: no start.
- **Write hazard:** during step 2, rewrite entry 2 to NOTE_C7.
  - Current step keeps its old note.
  - With `loop`=1, the second pass plays 0x80 at step 2.
  - A `start` pulse while busy has no effect.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: step-table entry layout, FSM states
// and the note codes that index the buzzer decoder outputs.
package note_seq_pkg;

    typedef struct packed {
        logic       rest;
        logic [1:0] dur;
        logic [2:0] note;
    } step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [2:0] NOTE_G6 = 3'd0;
    localparam logic [2:0] NOTE_F6 = 3'd1;
    localparam logic [2:0] NOTE_D6 = 3'd2;
    localparam logic [2:0] NOTE_B7 = 3'd3;
    localparam logic [2:0] NOTE_C6 = 3'd4;
    localparam logic [2:0] NOTE_A7 = 3'd5;
    localparam logic [2:0] NOTE_E6 = 3'd6;
    localparam logic [2:0] NOTE_C7 = 3'd7;

    function automatic logic [7:0] note_onehot(input step_t s);
        return s.rest ? 8'h00 : (8'h01 << s.note);
    endfunction

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// Prescaler plus 2-bit beat counter; expire is high in the last cycle of a
// segment lasting (beats+1)*(term+1) cycles after the cycle clear is released.
module beat_timer #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [1:0]    beats,
    input  logic [PW-1:0] term,
    output logic          expire
);

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    beat_q, beat_d;

    always_comb begin
        pre_d  = pre_q + PW'(1);
        beat_d = beat_q;
        if (clear) begin
            pre_d  = '0;
            beat_d = '0;
        end else if (pre_q == term) begin
            pre_d  = '0;
            beat_d = beat_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            beat_q <= '0;
        end else begin
            pre_q  <= pre_d;
            beat_q <= beat_d;
        end
    end

    assign expire = (pre_q == term) && (beat_q == beats);

endmodule

// File: rtl/note_sequencer.sv
// Programmable melody scheduler: plays a writable step table onto eight
// one-hot buzzer enables with start/stop/loop control.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int TICK_DIV   = 1000,
    parameter int GAP_CYCLES = 2,
    parameter int STEPS      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [5:0] wr_data,
    output logic [7:0] buzzer_en,
    output logic [2:0] step_idx,
    output logic       busy,
    output logic       done
);

    localparam int MAXDIV        = (TICK_DIV > GAP_CYCLES) ? TICK_DIV : GAP_CYCLES;
    localparam int PW            = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
    localparam int GAP_TERM      = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [2:0] LAST  = 3'(STEPS - 1);

    state_t     state_q, state_d;
    step_t      table_q [8];
    step_t      cur_q, cur_d;
    logic [2:0] ptr_q, ptr_d, nxt;
    logic [7:0] buzzer_q, buzzer_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       clear, adv, expire;
    logic [PW-1:0] term;

    // Gap segments reuse the timer as a plain cycle counter.
    assign term = (state_q == GAP) ? PW'(GAP_TERM) : PW'(TICK_DIV - 1);

    beat_timer #(.PW(PW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .beats  ((state_q == PLAY) ? cur_q.dur : 2'd0),
        .term   (term),
        .expire (expire)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        buzzer_d = buzzer_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clear    = 1'b0;
        adv      = 1'b0;
        nxt      = (ptr_q == LAST) ? 3'd0 : ptr_q + 3'd1;
        case (state_q)
            IDLE: begin
                clear = 1'b1;
                if (start) begin
                    state_d  = PLAY;
                    ptr_d    = 3'd0;
                    cur_d    = table_q[0];
                    buzzer_d = note_onehot(table_q[0]);
                    busy_d   = 1'b1;
                end
            end
            PLAY: begin
                if (expire) begin
                    clear = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d  = GAP;
                        buzzer_d = 8'h00;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            GAP: begin
                if (expire) begin
                    clear = 1'b1;
                    adv   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (ptr_q != LAST || loop) begin
                state_d  = PLAY;
                ptr_d    = nxt;
                cur_d    = table_q[nxt];
                buzzer_d = note_onehot(table_q[nxt]);
            end else begin
                state_d  = IDLE;
                ptr_d    = 3'd0;
                buzzer_d = 8'h00;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
        end
        // Abort wins over start, step advance and loop wrap.
        if (stop) begin
            state_d  = IDLE;
            ptr_d    = 3'd0;
            buzzer_d = 8'h00;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            clear    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 3'd0;
            cur_q    <= '0;
            buzzer_q <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 8; i++) table_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (wr_en) table_q[wr_addr] <= step_t'(wr_data);
        end
    end

    assign buzzer_en = buzzer_q;
    assign step_idx  = ptr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a per-cycle behavioural model.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [5:0] wr_data = 6'd0;
    logic [7:0] buzzer_en;
    logic [2:0] step_idx;
    logic       busy, done;

    int nchk = 0;
    int nerr = 0;

    note_sequencer #(.TICK_DIV(4), .GAP_CYCLES(2), .STEPS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .buzzer_en(buzzer_en), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a melody is a list of steps; each step is (dur+1)*4 sounding
    // cycles followed by 2 silent ones. m_t is the cycle offset into the step.
    logic [5:0] m_tab [8];
    logic [5:0] m_entry;
    bit         m_busy, m_done, chk_en;
    int         m_step, m_t;

    function automatic int step_len(input logic [5:0] e);
        return (int'(e[4:3]) + 1) * 4;
    endfunction

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_step = 0; m_t = 0; m_entry = '0;
            for (int i = 0; i < 8; i++) m_tab[i] = '0;
        end else begin
            m_done = 0;
            if (stop) begin
                m_busy = 0; m_step = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_step = 0; m_t = 0; m_entry = m_tab[0];
                end
            end else begin
                m_t++;
                if (m_t == step_len(m_entry) + 2) begin
                    if (m_step < 7 || loop) begin
                        m_step = (m_step + 1) % 8; m_t = 0; m_entry = m_tab[m_step];
                    end else begin
                        m_busy = 0; m_done = 1; m_step = 0;
                    end
                end
            end
            if (wr_en) m_tab[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_buzzer", int'(buzzer_en),
                (m_busy && m_t < step_len(m_entry) && !m_entry[5]) ? (1 << m_entry[2:0]) : 0);
            chk("model_step", int'(step_idx), m_busy ? m_step : 0);
            chk("model_busy", int'(busy), int'(m_busy));
            chk("model_done", int'(done), int'(m_done));
        end
    end

    task automatic wr(input logic [2:0] a, input logic [5:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    // One full non-looping pass of 1-beat steps, checked against cycle numbers.
    task automatic run_uniform(input bit scale);
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            start = 1'b0;
            begin
                int k = (n - 1) / 6;
                int r = (n - 1) % 6;
                chk("lit_buzzer", int'(buzzer_en),
                    (n <= 48 && r < 4) ? (scale ? (1 << k) : 1) : 0);
                if (n <= 48) chk("lit_step", int'(step_idx), k);
                chk("lit_done", int'(done), (n == 49) ? 1 : 0);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_buzzer", int'(buzzer_en), 0);
        chk("rst_step", int'(step_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // Cleared table plays note 0, one beat per step.
        run_uniform(1'b0);

        // Scale, no loop.
        for (int k = 0; k < 8; k++) wr(3'(k), {1'b0, 2'd0, 3'(k)});
        wr_end();
        run_uniform(1'b1);

        // Duration and rest.
        wr(3'd0, 6'b0_11_101);
        wr(3'd1, 6'b1_01_011);
        wr_end();
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(negedge clk);
            start = 1'b0;
            chk("dur_buzzer", int'(buzzer_en), (n <= 16) ? 8'h20 : 0);
        end
        wait_done(100);

        // Loop: wrap to step 0 without done, then finish after dropping loop.
        wr(3'd0, 6'd0);
        wr(3'd1, 6'd1);
        wr_end();
        loop = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 55; n++) begin
            @(negedge clk);
            start = 1'b0;
            chk("loop_done", int'(done), 0);
            if (n == 49) begin
                chk("loop_wrap_step", int'(step_idx), 0);
                chk("loop_wrap_buzzer", int'(buzzer_en), 8'h01);
            end
        end
        loop = 1'b0;
        wait_done(100);

        // Stop mid-play of step 3.
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("stop_pre_buzzer", int'(buzzer_en), 8'h08);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_buzzer", int'(buzzer_en), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_step", int'(step_idx), 0);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            chk("stop_nodone", int'(done), 0);
        end
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", int'(busy), 0);
        @(negedge clk);
        chk("startstop_busy2", int'(busy), 0);

        // Write hazard on the playing step, plus start while busy.
        loop = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            start = (n == 14);
            wr_en = (n == 13);
            wr_addr = 3'd2;
            wr_data = 6'b0_00_111;
            if (n == 15) chk("hz_old_note", int'(buzzer_en), 8'h04);
            if (n == 19) chk("hz_no_restart", int'(step_idx), 3);
            if (n == 61) begin
                chk("hz_new_note", int'(buzzer_en), 8'h80);
                chk("hz_new_step", int'(step_idx), 2);
            end
        end
        start = 1'b0; wr_en = 1'b0; loop = 1'b0;
        wait_done(100);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
